// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the helper that sizes the bit counter.
package serial_add_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter must hold values 0..WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between the register-file/ALU wrapper (master)
// and the bit-serial adder controller (slave).
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// 1-bit full adder assembled from two half-adder cells. Purely
// combinational; the carry state lives in the controller.
module serial_ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  // Half adder: sum is the XOR, carry is the AND.
  always_comb begin
    s = x ^ y;
    c = x & y;
  end

endmodule

module serial_fa_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic carry,
  output logic s,
  output logic c
);

  logic p;
  logic g1;
  logic g2;

  serial_ha_cell u_ha1 (
    .x (a_bit),
    .y (b_bit),
    .s (p),
    .c (g1)
  );

  serial_ha_cell u_ha2 (
    .x (p),
    .y (carry),
    .s (s),
    .c (g2)
  );

  // A carry out is generated by either half adder; both can never be set.
  always_comb begin
    c = g1 | g2;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures operands on start, walks them
// LSB first through one full-adder cell over WIDTH cycles, and publishes
// a held sum/carry-out with a single-cycle done pulse.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_add_ctrl_if.slave    bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;
  logic             done_q,   done_d;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] sum_sr_next;

  serial_fa_cell u_fa (
    .a_bit (a_sr_q[0]),
    .b_bit (b_sr_q[0]),
    .carry (carry_q),
    .s     (fa_s),
    .c     (fa_c)
  );

  // Partial sum after inserting this cycle's bit at the MSB end.
  always_comb begin
    sum_sr_next            = sum_sr_q >> 1;
    sum_sr_next[WIDTH-1]   = fa_s;
  end

  // Next-state and datapath control; every register holds by default.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          carry_d  = bus.cin;
          cnt_d    = '0;
          sum_sr_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_sr_next;
        carry_d  = fa_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = sum_sr_next;
          cout_d  = fa_c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
    end
  end

  // Drive the result side of the bundle straight from registers.
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = done_q;
    bus.sum  = sum_q;
    bus.cout = cout_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised bench for serial_add_ctrl at WIDTH 8, 1 and 32.
module tb_serial_add_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_add_ctrl_if #(.WIDTH(8))  bus8  ();
  serial_add_ctrl_if #(.WIDTH(1))  bus1  ();
  serial_add_ctrl_if #(.WIDTH(32)) bus32 ();

  serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_add_ctrl #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  serial_add_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL reset_w8: got busy=%b done=%b cout=%b sum=%h required all zero",
               bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    checks++;
    if ({bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_w1: got busy=%b done=%b cout=%b sum=%b required all zero",
               bus1.busy, bus1.done, bus1.cout, bus1.sum);
    end
    checks++;
    if ({bus32.busy, bus32.done, bus32.cout, bus32.sum} !== 35'h0) begin
      errors++;
      $display("[TB] FAIL reset_w32: got busy=%b done=%b cout=%b sum=%h required all zero",
               bus32.busy, bus32.done, bus32.cout, bus32.sum);
    end
  endtask

  // FF + 01 + 0: carry ripples through every bit.
  task automatic test_basic();
    bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0; bus8.a = 8'h3C; bus8.b = 8'hC3; bus8.cin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bus8.busy, bus8.done, bus8.sum} !== {2'b10, 8'h00}) begin
        errors++;
        $display("[TB] FAIL basic_run%0d: got busy=%b done=%b sum=%h required busy=1 done=0 sum=00",
                 i, bus8.busy, bus8.done, bus8.sum);
      end
      if (i < 7) tick();
    end
    tick();
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {3'b011, 8'h00}) begin
      errors++;
      $display("[TB] FAIL basic_done: got busy=%b done=%b cout=%b sum=%h required busy=0 done=1 cout=1 sum=00",
               bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    tick();
    checks++;
    if ({bus8.done, bus8.cout, bus8.sum} !== {2'b01, 8'h00}) begin
      errors++;
      $display("[TB] FAIL basic_after: got done=%b cout=%b sum=%h required done=0 cout=1 sum=00",
               bus8.done, bus8.cout, bus8.sum);
    end
  endtask

  // 5A+A5+1 then 12+34+0 issued in the done cycle.
  task automatic test_back_to_back();
    bus8.a = 8'h5A; bus8.b = 8'hA5; bus8.cin = 1'b1; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (8) tick();
    checks++;
    if ({bus8.done, bus8.cout, bus8.sum} !== {2'b11, 8'h00}) begin
      errors++;
      $display("[TB] FAIL b2b_first: got done=%b cout=%b sum=%h required done=1 cout=1 sum=00",
               bus8.done, bus8.cout, bus8.sum);
    end
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    checks++;
    if ({bus8.busy, bus8.done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got busy=%b done=%b required busy=1 done=0",
               bus8.busy, bus8.done);
    end
    repeat (7) tick();
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum} !== {2'b10, 8'h00}) begin
      errors++;
      $display("[TB] FAIL b2b_hold: got busy=%b done=%b sum=%h required busy=1 done=0 sum=00",
               bus8.busy, bus8.done, bus8.sum);
    end
    tick();
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {3'b010, 8'h46}) begin
      errors++;
      $display("[TB] FAIL b2b_second: got busy=%b done=%b cout=%b sum=%h required busy=0 done=1 cout=0 sum=46",
               bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    tick();
  endtask

  // Start pulsed mid-run must not disturb 0F+01.
  task automatic test_ignore_start();
    bus8.a = 8'h0F; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (3) tick();
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    checks++;
    if ({bus8.busy, bus8.done, bus8.sum} !== {2'b10, 8'h46}) begin
      errors++;
      $display("[TB] FAIL ignore_hold: got busy=%b done=%b sum=%h required busy=1 done=0 sum=46",
               bus8.busy, bus8.done, bus8.sum);
    end
    repeat (4) tick();
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {3'b010, 8'h10}) begin
      errors++;
      $display("[TB] FAIL ignore_result: got busy=%b done=%b cout=%b sum=%h required busy=0 done=1 cout=0 sum=10",
               bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    tick();
    checks++;
    if ({bus8.busy, bus8.done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL ignore_norestart: got busy=%b done=%b required busy=0 done=0",
               bus8.busy, bus8.done);
    end
  endtask

  // Reset asserted part-way through a run, then a clean 03+04.
  task automatic test_reset_mid();
    int done_seen;
    bus8.a = 8'h77; bus8.b = 8'h11; bus8.cin = 1'b1; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'h000) begin
      errors++;
      $display("[TB] FAIL midreset_async: got busy=%b done=%b cout=%b sum=%h required all zero",
               bus8.busy, bus8.done, bus8.cout, bus8.sum);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus8.done || bus8.busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("[TB] FAIL midreset_nodone: got %0d cycles with busy/done high required 0", done_seen);
    end
    bus8.a = 8'h03; bus8.b = 8'h04; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (8) tick();
    checks++;
    if ({bus8.done, bus8.cout, bus8.sum} !== {2'b10, 8'h07}) begin
      errors++;
      $display("[TB] FAIL midreset_after: got done=%b cout=%b sum=%h required done=1 cout=0 sum=07",
               bus8.done, bus8.cout, bus8.sum);
    end
    tick();
  endtask

  // Single-bit instance: done one cycle after the accepting edge.
  task automatic test_width1();
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1; bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.cin = 1'b0;
    checks++;
    if ({bus1.busy, bus1.done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL w1_run: got busy=%b done=%b required busy=1 done=0", bus1.busy, bus1.done);
    end
    tick();
    checks++;
    if ({bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL w1_done: got busy=%b done=%b cout=%b sum=%b required busy=0 done=1 cout=1 sum=1",
               bus1.busy, bus1.done, bus1.cout, bus1.sum);
    end
    tick();
    checks++;
    if ({bus1.done, bus1.cout, bus1.sum} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL w1_after: got done=%b cout=%b sum=%b required done=0 cout=1 sum=1",
               bus1.done, bus1.cout, bus1.sum);
    end
  endtask

  // Random operations at WIDTH=8 with fixed-latency checks.
  task automatic test_random_w8();
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] expected;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      expected = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      bus8.a = ra; bus8.b = rb; bus8.cin = rc; bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      repeat (7) tick();
      checks++;
      if ({bus8.busy, bus8.done} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL rand8_early op%0d: got busy=%b done=%b required busy=1 done=0",
                 n, bus8.busy, bus8.done);
      end
      tick();
      checks++;
      if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== {2'b01, expected}) begin
        errors++;
        $display("[TB] FAIL rand8_result op%0d: %h+%h+%b got busy=%b done=%b {cout,sum}=%h required %h",
                 n, ra, rb, rc, bus8.busy, bus8.done, {bus8.cout, bus8.sum}, expected);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();
  endtask

  // Random operations at WIDTH=32 with fixed-latency checks.
  task automatic test_random_w32();
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] expected;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      expected = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      bus32.a = ra; bus32.b = rb; bus32.cin = rc; bus32.start = 1'b1;
      tick();
      bus32.start = 1'b0; bus32.a = $urandom; bus32.b = $urandom; bus32.cin = 1'($urandom);
      repeat (31) tick();
      checks++;
      if ({bus32.busy, bus32.done} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL rand32_early op%0d: got busy=%b done=%b required busy=1 done=0",
                 n, bus32.busy, bus32.done);
      end
      tick();
      checks++;
      if ({bus32.busy, bus32.done, bus32.cout, bus32.sum} !== {2'b01, expected}) begin
        errors++;
        $display("[TB] FAIL rand32_result op%0d: %h+%h+%b got busy=%b done=%b {cout,sum}=%h required %h",
                 n, ra, rb, rc, bus32.busy, bus32.done, {bus32.cout, bus32.sum}, expected);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();
  endtask

  // Scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
    bus1.start  = 1'b0; bus1.a  = '0; bus1.b  = '0; bus1.cin  = 1'b0;
    bus32.start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0;
    #12;
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_width1();
    test_random_w8();
    test_random_w32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller for multi-bit operands.
- Time-shares one 1-bit full-adder cell, built from two half-adder cells, across WIDTH cycles, LSB first.
- Captures operands on a start handshake, carries between bits in a flip-flop, and presents a held result with a one-cycle done pulse.
- Sits between a register-file/ALU wrapper and the 1-bit adder cells in the lab datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured with a and b.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when the result updates.
- sum  output  WIDTH  last completed sum; held.
- cout  output  1  last completed carry-out; held.

Behaviour:
- Clock and reset:
  - Single clock: clk.
  - Reset is asynchronous and active-low: rst_n.
  - While rst_n=0: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, shift registers=0.
- FSM states:
  - IDLE: busy=0. If start=1 at an edge (call it edge k), then load a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, clear sum_sr, and go to RUN.
  - RUN: busy=1. At each edge:
    - Compute s,c = FA(a_sr[0], b_sr[0], carry).
    - Shift a_sr and b_sr right by 1.
    - Shift s into sum_sr at bit WIDTH-1.
    - carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge, that is the final bit:
    - sum<=shifted sum_sr including s; cout<=c.
    - done<=1; go to IDLE.
- Timing:
  - Final edge is k+WIDTH.
  - busy is high from edge k through edge k+WIDTH, then falls at k+WIDTH.
  - done is high for exactly the cycle after edge k+WIDTH and clears at the next edge.
  - Latency from start sample to done is WIDTH cycles.
- Handshake and boundary rules:
  - start while busy=1 is ignored: no restart, no queuing, no effect on the current operation.
  - start in the cycle where done=1 (state is IDLE) is accepted. This allows back-to-back operations with zero idle cycles.
  - sum and cout change only at completion edges and hold their values across an in-flight operation.
  - a, b and cin are don't-care except at the accepted start edge.
  - WIDTH=1: RUN lasts one edge; done follows one cycle after start.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1). No overflow flag.
- Reset mid-operation: the operation is aborted, all outputs return to reset values immediately, and no done pulse is issued.
- Full-adder cell: two half-adder cells.
  - HA1(a_bit, b_bit) -> p, g1.
  - HA2(p, carry) -> s, g2.
  - c = g1 | g2.
  - Purely combinational; the only state is the carry flop.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=1'b0, RUN=1'b1.
  - function to compute CNT_W.
- One sub-module: serial_fa_cell, a 1-bit full adder instantiating two half-adder cells.
- The FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan:
- WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulsed at edge k -> busy high for 8 cycles; done pulse after edge k+8; sum=8'h00, cout=1.
- a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1. Then a=8'h12, b=8'h34, cin=0 issued during the done cycle -> accepted; second done exactly 8 cycles later; sum=8'h46, cout=0.
- During RUN of 8'h0F+8'h01, pulse start with a=8'hAA -> ignored; result sum=8'h10, cout=0; sum output holds the previous value until completion.
- Assert rst_n=0 at cycle 4 of RUN -> busy, done, sum and cout go to 0 asynchronously, no done pulse. After release, 8'h03+8'h04 -> sum=8'h07.
- WIDTH=1: a=1, b=1, cin=1 -> done one cycle after start; sum=1, cout=1.
- Randomised 1000 operations at WIDTH=8 and WIDTH=32 against the reference model a+b+cin. Check that every done pulse has a fixed latency of WIDTH cycles.
